sync_fifo: RTL and testbench

//  Parametrised single-clock FIFO with full/empty handshake; replaces fixed 8x8 shift-register FIFOs.

---
 rtl/sync_fifo_pkg.sv | 19 +
 rtl/sync_fifo_mem.sv | 26 ++
 rtl/sync_fifo.sv | 122 ++++++++++++
 tb/tb_sync_fifo.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for sync_fifo: default geometry, ceil-log2 for widths,
// and the pointer increment that wraps at DEPTH-1 so non-power-of-two depths work.
package sync_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the owning FIFO tracks validity.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = clog2(DEF_DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a write at edge N is readable right after edge N, with no WR_EN->RD_DATA or RD_EN->FULL path.
// Writes while FULL and reads while EMPTY are dropped and set sticky OVF/UDF; SYNC_FIFO_LEVEL_EN adds LEVEL/ALMOST_* outputs.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH
`ifdef SYNC_FIFO_LEVEL_EN
  ,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
`endif
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        WR_EN,
  input  logic [WIDTH-1:0]            WR_DATA,
  output logic                        FULL,
  input  logic                        RD_EN,
  output logic [WIDTH-1:0]            RD_DATA,
  output logic                        EMPTY,
  output logic                        OVF,
`ifdef SYNC_FIFO_LEVEL_EN
  output logic                        UDF,
  output logic [clog2(DEPTH+1)-1:0]   LEVEL,
  output logic                        ALMOST_FULL,
  output logic                        ALMOST_EMPTY
`else
  output logic                        UDF
`endif
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_acc, rd_acc;

  assign wr_acc = WR_EN && !full_q;
  assign rd_acc = RD_EN && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = PTR_W'(ptr_inc(int'(wr_ptr_q), DEPTH));
    if (rd_acc) rd_ptr_d = PTR_W'(ptr_inc(int'(rd_ptr_q), DEPTH));
    if (wr_acc && !rd_acc) count_d = count_q + CNT_W'(1);
    if (rd_acc && !wr_acc) count_d = count_q - CNT_W'(1);
    // Flags come from count_d so they are registered yet line up with the pointer update.
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
    ovf_d   = ovf_q || (WR_EN && full_q);
    udf_d   = udf_q || (RD_EN && empty_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (CLK),
    .wr_en   (wr_acc),
    .wr_ptr  (wr_ptr_q),
    .wr_data (WR_DATA),
    .rd_ptr  (rd_ptr_q),
    .rd_data (RD_DATA)
  );

  assign FULL  = full_q;
  assign EMPTY = empty_q;
  assign OVF   = ovf_q;
  assign UDF   = udf_q;

`ifdef SYNC_FIFO_LEVEL_EN
  logic [CNT_W-1:0] level_q;
  logic             af_q, ae_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      level_q <= '0;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      level_q <= count_d;
      af_q    <= (int'(count_d) >= AF_THRESH);
      ae_q    <= (int'(count_d) <= AE_THRESH);
    end
  end

  assign LEVEL        = level_q;
  assign ALMOST_FULL  = af_q;
  assign ALMOST_EMPTY = ae_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised and directed bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             CLK = 1'b0;
  logic             RST, WR_EN, RD_EN;
  logic [WIDTH-1:0] WR_DATA, RD_DATA;
  logic             FULL, EMPTY, OVF, UDF;
`ifdef SYNC_FIFO_LEVEL_EN
  logic [LW-1:0]    LEVEL;
  logic             ALMOST_FULL, ALMOST_EMPTY;
`endif

  always #5 CLK = ~CLK;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .WR_EN        (WR_EN),
    .WR_DATA      (WR_DATA),
    .FULL         (FULL),
    .RD_EN        (RD_EN),
    .RD_DATA      (RD_DATA),
    .EMPTY        (EMPTY),
    .OVF          (OVF),
`ifdef SYNC_FIFO_LEVEL_EN
    .UDF          (UDF),
    .LEVEL        (LEVEL),
    .ALMOST_FULL  (ALMOST_FULL),
    .ALMOST_EMPTY (ALMOST_EMPTY)
`else
    .UDF          (UDF)
`endif
  );

  logic [WIDTH-1:0] model_q[$];
  bit               m_ovf, m_udf;
  int               n_chk = 0;
  int               n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("empty", 32'(EMPTY), 32'(model_q.size() == 0));
    chk("full",  32'(FULL),  32'(model_q.size() == DEPTH));
    chk("ovf",   32'(OVF),   32'(m_ovf));
    chk("udf",   32'(UDF),   32'(m_udf));
    if (model_q.size() > 0) chk("rd_data", 32'(RD_DATA), 32'(model_q[0]));
`ifdef SYNC_FIFO_LEVEL_EN
    chk("level", 32'(LEVEL), 32'(model_q.size()));
    chk("almost_full",  32'(ALMOST_FULL),  32'(model_q.size() >= DEPTH - 2));
    chk("almost_empty", 32'(ALMOST_EMPTY), 32'(model_q.size() <= 2));
`endif
  endtask

  // Drive one cycle, advance the model by the FIFO rules, then compare after the edge.
  task automatic cycle(input bit rst, input bit wr, input logic [WIDTH-1:0] d, input bit rd);
    RST = rst; WR_EN = wr; WR_DATA = d; RD_EN = rd;
    @(posedge CLK);
    if (rst) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      bit was_full, was_empty;
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      if (wr && was_full)  m_ovf = 1'b1;
      if (rd && was_empty) m_udf = 1'b1;
      if (rd && !was_empty) void'(model_q.pop_front());
      if (wr && !was_full)  model_q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    RST = 1'b1; WR_EN = 1'b0; RD_EN = 1'b0; WR_DATA = '0;

    // Reset state
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("rst_empty", 32'(EMPTY), 32'd1);
    chk("rst_full",  32'(FULL),  32'd0);

    // Fill to full, then drain in order
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, WIDTH'(8'h11 + i), 0);
    chk("fill_full", 32'(FULL), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 32'(RD_DATA), 32'(8'h11 + i));
      cycle(0, 0, 0, 1);
    end
    chk("drain_empty", 32'(EMPTY), 32'd1);

    // Simultaneous read/write while full: read wins, write dropped
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, WIDTH'(8'h11 + i), 0);
    cycle(0, 1, 8'hAA, 1);
    chk("full_rw_ovf",  32'(OVF),     32'd1);
    chk("full_rw_full", 32'(FULL),    32'd0);
    chk("full_rw_head", 32'(RD_DATA), 32'h12);
    for (int i = 0; i < DEPTH - 1; i++) cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);

    // Simultaneous read/write while empty: write wins, read dropped
    cycle(0, 1, 8'h5C, 1);
    chk("empty_rw_udf",  32'(UDF),     32'd1);
    chk("empty_rw_data", 32'(RD_DATA), 32'h5C);
    cycle(1, 0, 0, 0);

    // Pointer wrap across DEPTH-1 -> 0
    for (int i = 0; i < 5; i++) cycle(0, 1, WIDTH'(8'h20 + i), 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cycle(0, 1, WIDTH'(8'h30 + i), 0);
    chk("wrap_full", 32'(FULL), 32'd1);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 1);

    // Reset mid-operation discards contents
    for (int i = 0; i < 4; i++) cycle(0, 1, WIDTH'(8'h40 + i), 0);
    cycle(1, 0, 0, 0);
    chk("midrst_empty", 32'(EMPTY), 32'd1);
    cycle(0, 1, 8'h3C, 0);
    chk("midrst_data", 32'(RD_DATA), 32'h3C);

    // Random phases with varying write/read bias
    for (int ph = 0; ph < 15; ph++) begin
      int unsigned wp;
      wp = $urandom_range(10, 90);
      for (int k = 0; k < 200; k++) begin
        bit r, w, rd;
        r  = ($urandom_range(0, 299) == 0);
        w  = ($urandom_range(0, 99) < wp);
        rd = ($urandom_range(0, 99) >= wp);
        cycle(r, w, WIDTH'($urandom), rd);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
